mc_ctrl_fsm: RTL

- Multi-cycle control unit of the single-issue CPU; it is the initiator side of the ALU interface.
- Sequences FETCH, DECODE, EXEC, MEM and WB.
- Drives the 6-bit ALU opcode and operand select, consumes the ALU zero flag, and handshakes with the unified memory port for both instruction and data accesses.
- Produces every datapath write-enable plus a retired-instruction counter.

---
 rtl/mc_ctrl_fsm_pkg.sv | 38 +++
 rtl/mc_ctrl_fsm_timeout.sv | 32 +++
 rtl/mc_ctrl_fsm.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared opcode constants, state encodings and next-PC select codes for the multi-cycle controller.
package mc_ctrl_fsm_pkg;

  localparam logic [5:0] OP_JUMP = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_LDW  = 6'h23;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_XOR  = 6'h26;
  localparam logic [5:0] OP_SLT  = 6'h2A;
  localparam logic [5:0] OP_SDW  = 6'h2B;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2
  } pc_sel_e;

  function automatic logic is_known_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
      OP_LDW, OP_SDW, OP_BEQ, OP_JUMP: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_timeout.sv
// Memory wait-cycle counter: saturates at MAX and flags expiry; MAX = 0 never expires.
module mc_ctrl_timeout #(
  parameter int unsigned MAX = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = (MAX == 0) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] LIM = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (MAX != 0) && (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !expired_o)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/FAULT) with memory timeout and retire counter.
// ILLEGAL_TRAP_EN: when defined, unknown opcodes trap to FAULT; otherwise they retire as NOPs.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       ir_opcode,
  input  logic             zf,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic [5:0]       alu_opcode,
  output logic             alu_src_imm,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             ack, waiting, expired, retire;

  // Qualify by rst_n so a request or ack action cannot leak out while reset is held.
  assign ack     = mem_ack & rst_n;
  assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

  mc_ctrl_timeout #(.MAX(TIMEOUT_CYC)) u_timeout (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .clr_i     (!waiting || ack),
    .en_i      (waiting),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we       = 1'b0;
    alu_opcode  = '0;
    alu_src_imm = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_SEQ;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = rst_n & !expired;
        if (ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        alu_opcode = ir_opcode;
        if (is_known_op(ir_opcode)) begin
          state_d = ST_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ST_FAULT;
`else
          state_d = ST_FETCH;
          retire  = 1'b1;
`endif
        end
      end
      ST_EXEC: begin
        alu_opcode  = ir_opcode;
        alu_src_imm = (ir_opcode == OP_LDW) || (ir_opcode == OP_SDW);
        case (ir_opcode)
          OP_LDW, OP_SDW: state_d = ST_MEM;
          OP_BEQ: begin
            pc_sel  = PC_BR;
            pc_we   = zf;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          OP_JUMP: begin
            pc_sel  = PC_JMP;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req  = rst_n & !expired;
        addr_sel = 1'b1;
        mem_we   = (ir_opcode == OP_SDW);
        if (ack) begin
          if (ir_opcode == OP_SDW) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (ir_opcode == OP_LDW);
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FAULT;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign fault   = (state_q == ST_FAULT);
  assign state_o = state_q;
  assign retired = retired_q;

endmodule
